cgra_store_unloader: RTL and testbench

- Host-side read-back engine for the 2x2 torus CGRA.
- After the PE array finishes, it reads result words from the array's two output buffers (Data0/Data1 store ports) over a contiguous address range.
- It serialises them onto an 8-bit valid/ready byte stream toward the narrow host I/O.
- It is the transmit-side counterpart of the byte-to-word load path that feeds Data0_Load/Data1_Load.

---
 rtl/cgra_store_unloader_if.sv | 32 +++
 rtl/cgra_store_unloader.sv | 82 ++++++++
 tb/tb_cgra_store_unloader.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_store_unloader_if.sv
// Bundle of the unloader's control, store-port and byte-stream signals.
// The master side is the host/array environment, the slave side is the unloader.
interface cgra_store_unloader_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
);
  logic              Start;
  logic [AWIDTH-1:0] Base_Addr;
  logic [AWIDTH:0]   Word_Count;
  logic              PE_Array_Busy;
  logic [AWIDTH-1:0] Store_Addr;
  logic              Store_Rd_En;
  logic [DWIDTH-1:0] Data0_Store;
  logic [DWIDTH-1:0] Data1_Store;
  logic [7:0]        D_out;
  logic              D_out_Valid;
  logic              D_out_Ready;
  logic              Busy;
  logic              Done;

  modport master (
    output Start, Base_Addr, Word_Count, PE_Array_Busy,
    output Data0_Store, Data1_Store, D_out_Ready,
    input  Store_Addr, Store_Rd_En, D_out, D_out_Valid, Busy, Done
  );

  modport slave (
    input  Start, Base_Addr, Word_Count, PE_Array_Busy,
    input  Data0_Store, Data1_Store, D_out_Ready,
    output Store_Addr, Store_Rd_En, D_out, D_out_Valid, Busy, Done
  );
endinterface

// File: rtl/cgra_store_unloader.sv
// Read-back engine: walks an address range of the two CGRA output buffers and
// serialises each {Data1, Data0} word pair onto an 8-bit valid/ready stream,
// Data0 bytes first, LSB first within each word.
module cgra_store_unloader #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input logic                 Clk,
  input logic                 Resetn,
  cgra_store_unloader_if.slave bus
);
  localparam int NB = 2 * DWIDTH / 8;   // bytes per address
  localparam int BW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE, WAIT_ARRAY, READ, CAPTURE, SEND, DONE
  } state_t;

  state_t              state;
  logic [AWIDTH-1:0]   addr;
  logic [AWIDTH:0]     remain;
  logic [2*DWIDTH-1:0] sreg;
  logic [BW-1:0]       bidx;

  wire last_byte = (bidx == BW'(NB - 1));

  // Control FSM and datapath: address/count bookkeeping, word capture, byte shifting.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      addr   <= '0;
      remain <= '0;
      sreg   <= '0;
      bidx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (bus.Word_Count != '0) begin
              addr   <= bus.Base_Addr;
              remain <= bus.Word_Count;
              state  <= WAIT_ARRAY;
            end else begin
              state  <= DONE;
            end
          end
        end
        // Array ownership is re-checked before every address.
        WAIT_ARRAY: if (!bus.PE_Array_Busy) state <= READ;
        READ:       state <= CAPTURE;
        // Buffer data is valid the cycle after the read strobe.
        CAPTURE: begin
          sreg  <= {bus.Data1_Store, bus.Data0_Store};
          bidx  <= '0;
          state <= SEND;
        end
        SEND: begin
          if (bus.D_out_Ready) begin
            sreg <= sreg >> 8;
            if (last_byte) begin
              addr   <= addr + 1'b1;       // wraps naturally at 2^AWIDTH
              remain <= remain - 1'b1;
              state  <= (remain != (AWIDTH+1)'(1)) ? WAIT_ARRAY : DONE;
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are straight decodes of flops, so they carry no combinational input paths.
  assign bus.Store_Addr  = addr;
  assign bus.Store_Rd_En = (state == READ);
  assign bus.D_out       = sreg[7:0];
  assign bus.D_out_Valid = (state == SEND);
  assign bus.Busy        = (state != IDLE);
  assign bus.Done        = (state == DONE);
endmodule

// File: tb/tb_cgra_store_unloader.sv
// Directed bench for cgra_store_unloader: buffer model, byte/address monitor,
// one task per scenario.
module tb_cgra_store_unloader;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 10;

  logic Clk;
  logic Resetn;

  cgra_store_unloader_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_if ();

  cgra_store_unloader #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (u_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DWIDTH-1:0] mem0 [0:(1<<AWIDTH)-1];
  logic [DWIDTH-1:0] mem1 [0:(1<<AWIDTH)-1];

  // Synchronous-read output buffers.
  always @(posedge Clk) begin
    if (u_if.Store_Rd_En) begin
      u_if.Data0_Store <= mem0[u_if.Store_Addr];
      u_if.Data1_Store <= mem1[u_if.Store_Addr];
    end
  end

  logic [7:0]        got_q  [$];
  logic [7:0]        exp_q  [$];
  logic [AWIDTH-1:0] addr_q [$];
  int                done_cnt = 0;
  logic              prev_stall = 1'b0;
  logic [7:0]        held;

  // Monitor: accepted bytes, read addresses, Done pulses, stall stability.
  always @(posedge Clk) begin
    if (!Resetn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && u_if.D_out_Valid) begin
        n_cmp++;
        if (u_if.D_out !== held) begin
          n_fail++;
          $display("FAIL stall_hold: D_out=%02h required %02h", u_if.D_out, held);
        end
      end
      if (u_if.D_out_Valid && u_if.D_out_Ready) got_q.push_back(u_if.D_out);
      if (u_if.Store_Rd_En) addr_q.push_back(u_if.Store_Addr);
      if (u_if.Done) done_cnt++;
      prev_stall <= u_if.D_out_Valid && !u_if.D_out_Ready;
      held       <= u_if.D_out;
    end
  end

  task automatic push_exp(input logic [AWIDTH-1:0] a);
    logic [DWIDTH-1:0] w0, w1;
    w0 = mem0[a];
    w1 = mem1[a];
    for (int i = 0; i < DWIDTH/8; i++) exp_q.push_back(w0[i*8 +: 8]);
    for (int i = 0; i < DWIDTH/8; i++) exp_q.push_back(w1[i*8 +: 8]);
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic start(input logic [AWIDTH-1:0] base, input logic [AWIDTH:0] cnt);
    u_if.Base_Addr  = base;
    u_if.Word_Count = cnt;
    u_if.Start      = 1'b1;
    @(negedge Clk);
    u_if.Start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (u_if.Done !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    n_cmp++;
    if (u_if.Done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: Done=%0b after %0d cycles, required 1", name, u_if.Done, n);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    int lat;
    // Reset state
    n_cmp++;
    if ({u_if.Store_Addr, u_if.Store_Rd_En, u_if.D_out, u_if.D_out_Valid, u_if.Busy, u_if.Done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%h rd=%b dout=%h v=%b busy=%b done=%b required all 0",
               u_if.Store_Addr, u_if.Store_Rd_En, u_if.D_out, u_if.D_out_Valid, u_if.Busy, u_if.Done);
    end
    @(negedge Clk);
    Resetn = 1'b1;
    @(negedge Clk);

    // Abort mid-SEND
    start(10'h007, 11'd1);
    lat = 0;
    while (u_if.D_out_Valid !== 1'b1 && lat < 50) begin @(negedge Clk); lat++; end
    repeat (2) @(negedge Clk);
    #2 Resetn = 1'b0;
    #1;
    n_cmp++;
    if ({u_if.Store_Addr, u_if.Store_Rd_En, u_if.D_out, u_if.D_out_Valid, u_if.Busy, u_if.Done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%h rd=%b dout=%h v=%b busy=%b done=%b required all 0",
               u_if.Store_Addr, u_if.Store_Rd_En, u_if.D_out, u_if.D_out_Valid, u_if.Busy, u_if.Done);
    end
    @(negedge Clk);
    Resetn = 1'b1;
    @(negedge Clk);

    // Single address after release, latency and Done timing
    clear_logs();
    mem0[5] = 32'h44332211;
    mem1[5] = 32'h88776655;
    u_if.Base_Addr  = 10'h005;
    u_if.Word_Count = 11'd1;
    u_if.Start      = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      u_if.Start = 1'b0;
      lat++;
    end while (u_if.D_out_Valid !== 1'b1 && lat < 50);
    n_cmp++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL first_valid_latency: %0d cycles, required 4", lat);
    end
    repeat (7) @(negedge Clk);
    n_cmp++;
    if (u_if.Done !== 1'b0 || u_if.D_out_Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL last_byte_cycle: done=%b valid=%b required 0/1", u_if.Done, u_if.D_out_Valid);
    end
    @(negedge Clk);
    n_cmp++;
    if (u_if.Done !== 1'b1 || u_if.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_after_last: done=%b busy=%b required 1/1", u_if.Done, u_if.Busy);
    end
    @(negedge Clk);
    n_cmp++;
    if (u_if.Done !== 1'b0 || u_if.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_idle: done=%b busy=%b required 0/0", u_if.Done, u_if.Busy);
    end
    n_cmp++;
    if (addr_q.size() != 1 || addr_q[0] !== 10'h005) begin
      n_fail++;
      $display("FAIL single_addr: n=%0d first=%h required 1 x 005", addr_q.size(),
               addr_q.size() > 0 ? addr_q[0] : 10'h3ff);
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'(8'h11 * (i + 1));
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== e) begin
        n_fail++;
        $display("FAIL single_byte%0d: got %h required %h", i, i < got_q.size() ? got_q[i] : 8'hxx, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AWIDTH-1:0] ea [3];
    ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000;
    clear_logs();
    for (int i = 0; i < 3; i++) push_exp(ea[i]);
    start(10'h3FE, 11'd3);
    wait_done("wrap", 100);
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (addr_q.size() != 3) begin
      n_fail++;
      $display("FAIL wrap_addr_count: %0d reads, required 3", addr_q.size());
    end
    for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
      n_cmp++;
      if (addr_q[i] !== ea[i]) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: %h required %h", i, addr_q[i], ea[i]);
      end
    end
    n_cmp++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL wrap_bytes: %0d bytes received, %0d expected, content differs", got_q.size(), exp_q.size());
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL wrap_done_pulses: %0d required 1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n;
    clear_logs();
    push_exp(10'h100);
    push_exp(10'h101);
    start(10'h100, 11'd2);
    n = 0;
    while (u_if.Done !== 1'b1 && n < 400) begin
      u_if.D_out_Ready = 1'($urandom_range(0, 1));
      @(negedge Clk);
      n++;
    end
    u_if.D_out_Ready = 1'b1;
    n_cmp++;
    if (u_if.Done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_timeout: Done=%0b after %0d cycles, required 1", u_if.Done, n);
    end
    @(negedge Clk);
    n_cmp++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL bp_scoreboard: %0d bytes received, %0d expected, content differs", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_array_busy();
    int n;
    // Held off before the first read
    clear_logs();
    push_exp(10'h010);
    u_if.PE_Array_Busy = 1'b1;
    start(10'h010, 11'd1);
    repeat (20) @(negedge Clk);
    n_cmp++;
    if (addr_q.size() != 0 || u_if.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_gate_reads: %0d reads busy=%b, required 0 reads busy=1", addr_q.size(), u_if.Busy);
    end
    u_if.PE_Array_Busy = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (u_if.Store_Rd_En !== 1'b1 || u_if.Store_Addr !== 10'h010) begin
      n_fail++;
      $display("FAIL busy_release_read: rd=%b addr=%h required 1/010", u_if.Store_Rd_En, u_if.Store_Addr);
    end
    wait_done("busy_gate", 50);
    n_cmp++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL busy_gate_bytes: %0d bytes received, %0d expected", got_q.size(), exp_q.size());
    end

    // Raised mid-SEND
    clear_logs();
    push_exp(10'h020);
    push_exp(10'h021);
    start(10'h020, 11'd2);
    n = 0;
    while (u_if.D_out_Valid !== 1'b1 && n < 50) begin @(negedge Clk); n++; end
    repeat (2) @(negedge Clk);
    u_if.PE_Array_Busy = 1'b1;
    repeat (15) @(negedge Clk);
    n_cmp++;
    if (got_q.size() != 8 || addr_q.size() != 1 || u_if.D_out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_mid_send: bytes=%0d reads=%0d valid=%b, required 8/1/0",
               got_q.size(), addr_q.size(), u_if.D_out_Valid);
    end
    u_if.PE_Array_Busy = 1'b0;
    wait_done("busy_mid", 60);
    n_cmp++;
    if (got_q != exp_q || addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL busy_mid_total: bytes=%0d reads=%0d required 16/2", got_q.size(), addr_q.size());
    end
  endtask

  task automatic test_zero_and_ignore();
    clear_logs();
    start(10'h050, 11'd0);
    n_cmp++;
    if (u_if.Done !== 1'b1 || u_if.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b required 1/1", u_if.Done, u_if.Busy);
    end
    repeat (5) @(negedge Clk);
    n_cmp++;
    if (addr_q.size() != 0 || got_q.size() != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_activity: reads=%0d bytes=%0d dones=%0d required 0/0/1",
               addr_q.size(), got_q.size(), done_cnt);
    end

    // Start pulses while Busy must not disturb the running range
    clear_logs();
    push_exp(10'h040);
    push_exp(10'h041);
    start(10'h040, 11'd2);
    repeat (2) @(negedge Clk);
    start(10'h080, 11'd5);
    repeat (4) @(negedge Clk);
    start(10'h0C0, 11'd0);
    wait_done("ignore", 100);
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (addr_q.size() != 2 || addr_q[0] !== 10'h040 || addr_q[addr_q.size()-1] !== 10'h041) begin
      n_fail++;
      $display("FAIL ignore_range: %0d reads, required 2 (040,041)", addr_q.size());
    end
    n_cmp++;
    if (got_q != exp_q || done_cnt != 1) begin
      n_fail++;
      $display("FAIL ignore_bytes: bytes=%0d dones=%0d required 16/1", got_q.size(), done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AWIDTH); i++) begin
      mem0[i] = 32'hA5000000 ^ (i * 32'h00010203);
      mem1[i] = 32'h5A000000 ^ (i * 32'h03020100) ^ 32'h0000C3C3;
    end
    mem0[10'h3FE] = 32'h03020100; mem1[10'h3FE] = 32'h07060504;
    mem0[10'h3FF] = 32'h0B0A0908; mem1[10'h3FF] = 32'h0F0E0D0C;
    mem0[10'h000] = 32'h13121110; mem1[10'h000] = 32'h17161514;
    Resetn             = 1'b0;
    u_if.Start         = 1'b0;
    u_if.Base_Addr     = '0;
    u_if.Word_Count    = '0;
    u_if.PE_Array_Busy = 1'b0;
    u_if.D_out_Ready   = 1'b1;
    u_if.Data0_Store   = '0;
    u_if.Data1_Store   = '0;
    #3;
    test_reset();
    test_wrap();
    test_backpressure();
    test_array_busy();
    test_zero_and_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
